// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data-length codes, divisor floor, parity helper.
// Latency: n/a (declarations and a combinational function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // data_len encoding: number of data bits is code + 5
    localparam logic [1:0] LEN5 = 2'd0;
    localparam logic [1:0] LEN6 = 2'd1;
    localparam logic [1:0] LEN7 = 2'd2;
    localparam logic [1:0] LEN8 = 2'd3;

    // Smallest usable clocks-per-bit; smaller divisors are raised to this
    localparam int MIN_DIV = 2;

    // Parity over the low (len+5) bits; even=1 makes the total ones count even
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic [1:0] len,
                                         input logic       even);
        logic [7:0] mask;
        logic       p;
        mask = 8'hFF >> (LEN8 - len);
        p    = ^(data & mask);
        return even ? p : ~p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with occupancy count, combinational head read.
// Latency: pushed entry visible at rd_dat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep level.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage write; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, runtime length/parity/stop/divisor, LSB first.
// Latency: push into empty idle FIFO drives the start bit on the 2nd edge after accept.
// Backpressure: tx_ready low while the FIFO is full; pushes then are dropped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter int  DIV_W      = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_start,
    output logic             tx_ready,
    input  logic [7:0]       data_in,
    input  logic [1:0]       data_len,
    input  logic             parity_en,
    input  logic             even_parity,
    input  logic             stop2,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tx,
    output logic             tx_busy,
    output logic             frame_done,
    output logic [LVL_W-1:0] fifo_level
);

    uart_tx_state_e state;
    uart_tx_state_e state_nxt;

    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] timer;
    logic [DIV_W-1:0] timer_nxt;
    logic             bit_end;

    // Per-frame latched configuration and datapath
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_nxt;
    logic [1:0]       len_q;
    logic [1:0]       len_nxt;
    logic             par_en_q;
    logic             par_en_nxt;
    logic             par_q;
    logic             par_nxt;
    logic             stop2_q;
    logic             stop2_nxt;
    logic             stop_cnt;
    logic             stop_cnt_nxt;

    logic             tx_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dat;

    assign eff_div  = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
    assign bit_end  = (timer == '0);
    assign tx_ready = !fifo_full;
    assign push     = tx_start && tx_ready;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wr_dat (data_in),
        .pop    (pop),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, bit sequencing, head pop and config latch
    always_comb begin
        state_nxt    = state;
        timer_nxt    = bit_end ? timer : timer - DIV_W'(1);
        div_nxt      = div_q;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        len_nxt      = len_q;
        par_en_nxt   = par_en_q;
        par_nxt      = par_q;
        stop2_nxt    = stop2_q;
        stop_cnt_nxt = stop_cnt;
        pop          = 1'b0;
        tx_nxt       = 1'b1;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                pop = !fifo_empty;
            end
            START: begin
                tx_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt   = DATA;
                    timer_nxt   = div_q - DIV_W'(1);
                    bit_cnt_nxt = {1'b0, len_q} + 3'd4;
                end
            end
            DATA: begin
                tx_nxt = shreg[0];
                if (bit_end) begin
                    timer_nxt    = div_q - DIV_W'(1);
                    shreg_nxt    = {1'b0, shreg[7:1]};
                    stop_cnt_nxt = stop2_q;
                    if (bit_cnt == 3'd0) begin
                        state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt - 3'd1;
                    end
                end
            end
            PARITY: begin
                tx_nxt = par_q;
                if (bit_end) begin
                    state_nxt = STOP;
                    timer_nxt = div_q - DIV_W'(1);
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    if (stop_cnt) begin
                        stop_cnt_nxt = 1'b0;
                        timer_nxt    = div_q - DIV_W'(1);
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                        pop       = !fifo_empty;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Pop the head: snapshot config so later input changes cannot disturb
        // the frame; even_parity is consumed here by precomputing the bit
        if (pop) begin
            state_nxt  = START;
            timer_nxt  = eff_div - DIV_W'(1);
            div_nxt    = eff_div;
            shreg_nxt  = fifo_dat;
            len_nxt    = data_len;
            par_en_nxt = parity_en;
            par_nxt    = calc_parity(fifo_dat, data_len, even_parity);
            stop2_nxt  = stop2;
        end

        busy_nxt = (state != IDLE);
    end

    // Datapath registers and registered pad-facing outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer      <= '0;
            div_q      <= DIV_W'(MIN_DIV);
            shreg      <= '0;
            bit_cnt    <= '0;
            len_q      <= LEN8;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            timer      <= timer_nxt;
            div_q      <= div_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            len_q      <= len_nxt;
            par_en_q   <= par_en_nxt;
            par_q      <= par_nxt;
            stop2_q    <= stop2_nxt;
            stop_cnt   <= stop_cnt_nxt;
            tx         <= tx_nxt;
            tx_busy    <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule
